apb_slave_waitmem: RTL
======================

# apb_slave_waitmem

Parametrised APB slave memory, next generation of the team's single-cycle APB RAM slave. It adds configurable address and data widths and depth, programmable wait states, per-byte write strobes, and an error response for out-of-range addresses. It sits behind the APB bridge as a word-addressed scratch RAM and is the reference DUT for wait-state and error coverage in the APB verification environment.

## Interface
Parameters:
- AWIDTH, default 8: address width, word address.
- DWIDTH, default 32: data width; must be a multiple of 8.
- DEPTH, default 256: number of words; must satisfy 1 <= DEPTH <= 2**AWIDTH.
- WAIT_STATES, default 0: extra wait cycles per transfer, range 0..15.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- p_sel, input, 1: slave select.
- p_en, input, 1: enable; high in the access phase.
- p_write, input, 1: 1 = write, 0 = read.
- addr, input, AWIDTH: word address.
- wdata, input, DWIDTH: write data.
- p_strb, input, DWIDTH/8: byte-lane write strobes; bit i qualifies wdata[8i+7:8i].
- rdata, output, DWIDTH: read data; registered.
- p_ready, output, 1: transfer complete; registered.
- p_slverr, output, 1: error response; valid only while p_ready = 1; registered.

## Operation
- FSM with three states: IDLE, WAIT, RESP.
- IDLE: on an edge with p_sel && p_en:
  - WAIT_STATES = 0 -> RESP, executing the transfer at that edge.
  - Otherwise -> WAIT, with cnt <= WAIT_STATES-1.
  - Any other input leaves the FSM in IDLE.
- WAIT: on each edge:
  - If p_sel = 0, abort -> IDLE. No memory update, p_ready stays 0.
  - Else if cnt = 0 -> RESP, executing the transfer.
  - Else cnt <= cnt-1.
  - In every case the address, direction, data and strobes used are those present at that edge.
- Executing the transfer, with err = (addr >= DEPTH):
  - err = 1: no memory write; rdata <= 0 on a read, unchanged on a write; p_slverr <= 1.
  - Write, err = 0: for each lane i with p_strb[i] = 1, ram[addr] lane i <= wdata lane i. Unstrobed lanes keep their value. p_strb = 0 is a legal no-op with no error. rdata is unchanged.
  - Read, err = 0: rdata <= ram[addr]; p_strb is ignored.
  - In all cases p_ready <= 1.
- RESP: p_ready = 1 for exactly one cycle. The next edge -> IDLE with p_ready <= 0 and p_slverr <= 0, whatever the inputs are. An access held across RESP is not re-executed.
- rdata holds its last value between reads.
- Reset (rst = 1, asynchronous): FSM -> IDLE, cnt = 0, p_ready = 0, p_slverr = 0, rdata = 0, all DEPTH words = 0. Reset that arrives during WAIT or RESP discards the transfer. The first edge after rst deasserts is an ordinary IDLE edge.

## Timing
- Access phase, counting the first cycle with p_sel && p_en as cycle 1: p_ready is high in cycle WAIT_STATES+2.
  - WAIT_STATES = 0: 2 access cycles, with p_ready in cycle 2, the same as the previous block.
  - WAIT_STATES = 3: p_ready in cycle 5.
- A write commits at the edge that ends the last wait cycle. It is visible to a read transfer that starts after RESP.
- Read data is valid in the same cycle p_ready is high and is held afterwards.
- Back-to-back transfers are limited by the APB setup phase. The minimum transfer period is setup + WAIT_STATES+2 cycles.
- There is no combinational path from any input to any output.

## Test plan
- Reset: assert rst mid-clock. Outputs go to 0 immediately without waiting for an edge. Afterwards, a read of addr 0x00 and a read of addr DEPTH-1 both return 0x0000_0000.
- Write/read, WAIT_STATES = 0: write 0xDEAD_BEEF to 0x10 with p_strb = 4'hF, then read 0x10. Response: p_ready in access cycle 2, rdata = 0xDEAD_BEEF, p_slverr = 0.
- Strobes: after the previous test, write 0x1122_3344 to 0x10 with p_strb = 4'b0101, then read 0x10. Response: rdata = 0xDE22_BE44. A write with p_strb = 0 leaves the word unchanged.
- Wait states, WAIT_STATES = 3: a read shows p_ready low for access cycles 1-4 and high in cycle 5. Drop p_sel in cycle 3 of a write: the memory is unchanged and p_ready is never asserted.
- Error, DEPTH = 200: write 0x55 to 200, then read 200. Each transfer gives p_ready = 1 and p_slverr = 1, and the read returns rdata = 0. A read of 199 returns its stored value with p_slverr = 0.
- Reset mid-transfer, WAIT_STATES = 3: assert rst during WAIT of a write to 0x20. Response: p_ready = 0, and a read of 0x20 after reset returns 0.

Source files
------------

// File: rtl/apb_slave_waitmem.sv
// Word-addressed APB scratch RAM with programmable wait states, byte-lane
// write strobes and an error response for addresses at or above DEPTH.
module apb_slave_waitmem #(
  parameter int AWIDTH      = 8,
  parameter int DWIDTH      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_sel,
  input  logic                  p_en,
  input  logic                  p_write,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH-1:0]     wdata,
  input  logic [DWIDTH/8-1:0]   p_strb,
  output logic [DWIDTH-1:0]     rdata,
  output logic                  p_ready,
  output logic                  p_slverr
);

  localparam int NLANES = DWIDTH / 8;
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [DWIDTH-1:0] ram [DEPTH];
  logic              err;
  logic              exec;
  logic [IW-1:0]     idx;

  // Handshake: a transfer starts on an edge with p_sel && p_en in IDLE, the
  // access executes on the edge that ends the last wait cycle, and p_ready is
  // high for exactly one cycle afterwards. Dropping p_sel during WAIT aborts.
  assign err  = {1'b0, addr} >= DEPTH_L;
  assign idx  = IW'(addr);
  assign exec = ((state == IDLE) && p_sel && p_en && (WAIT_STATES == 0)) ||
                ((state == WAIT) && p_sel && (cnt == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      p_ready  <= 1'b0;
      p_slverr <= 1'b0;
      rdata    <= '0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p_sel && p_en) begin
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!p_sel)           state <= IDLE;
          else if (cnt == 4'd0) state <= RESP;
          else                  cnt   <= cnt - 4'd1;
        end
        RESP: begin
          state    <= IDLE;
          p_ready  <= 1'b0;
          p_slverr <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (exec) begin
        p_ready  <= 1'b1;
        p_slverr <= err;
        if (err) begin
          if (!p_write) rdata <= '0;
        end else if (p_write) begin
          for (int l = 0; l < NLANES; l++) begin
            if (p_strb[l]) ram[idx][8*l +: 8] <= wdata[8*l +: 8];
          end
        end else begin
          rdata <= ram[idx];
        end
      end
    end
  end

endmodule
